// File: rtl/sr_latch_driver.sv
// Write sequencer for a gated SR latch: drives S/R with setup and hold around an
// En pulse, then compares the latch feedback against the written bit.
module sr_latch_driver #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1,
    parameter bit          SKIP_SAME = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic WrReq,
    input  logic WrData,
    input  logic Q_fb,
    output logic S,
    output logic R,
    output logic En,
    output logic Ready,
    output logic Done,
    output logic Err
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_d;
    logic             r_s;
    logic             r_r;
    logic             r_en;
    logic             r_ready;
    logic             r_done;
    logic             r_err;

    state_t           w_nxt_state;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_nxt_d;
    logic             w_nxt_s;
    logic             w_nxt_r;
    logic             w_nxt_en;
    logic             w_nxt_ready;
    logic             w_nxt_done;
    logic             w_nxt_err;
    logic             w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    // State and registered outputs; reset drops En immediately, aborting any write.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_d     <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_en    <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_d     <= w_nxt_d;
            r_s     <= w_nxt_s;
            r_r     <= w_nxt_r;
            r_en    <= w_nxt_en;
            r_ready <= w_nxt_ready;
            r_done  <= w_nxt_done;
            r_err   <= w_nxt_err;
        end
    end

    // Next state and next output values; S/R hold by default, En/Ready/Done pulse.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_d     = r_d;
        w_nxt_s     = r_s;
        w_nxt_r     = r_r;
        w_nxt_en    = 1'b0;
        w_nxt_ready = 1'b0;
        w_nxt_done  = 1'b0;
        w_nxt_err   = r_err;

        case (r_state)
            ST_IDLE: begin
                w_nxt_ready = 1'b1;
                w_nxt_s     = 1'b0;
                w_nxt_r     = 1'b0;
                if (WrReq && r_ready) begin
                    w_nxt_d     = WrData;
                    w_nxt_err   = 1'b0;
                    w_nxt_ready = 1'b0;
                    if (SKIP_SAME && (Q_fb == WrData)) begin
                        w_nxt_state = ST_DONE;
                        w_nxt_done  = 1'b1;
                    end else begin
                        w_nxt_state = ST_SETUP;
                        w_nxt_s     = WrData;
                        w_nxt_r     = ~WrData;
                        w_nxt_cnt   = SETUP_LOAD;
                    end
                end
            end

            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_nxt_state = ST_PULSE;
                    w_nxt_en    = 1'b1;
                    w_nxt_cnt   = PULSE_LOAD;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end

            ST_PULSE: begin
                if (!w_cnt_zero) begin
                    w_nxt_en  = 1'b1;
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end else if (HOLD_CYC > 0) begin
                    w_nxt_state = ST_HOLD;
                    w_nxt_cnt   = HOLD_LOAD;
                end else begin
                    w_nxt_state = ST_DONE;
                    w_nxt_done  = 1'b1;
                    w_nxt_err   = (Q_fb != r_d);
                    w_nxt_s     = 1'b0;
                    w_nxt_r     = 1'b0;
                end
            end

            ST_HOLD: begin
                if (w_cnt_zero) begin
                    w_nxt_state = ST_DONE;
                    w_nxt_done  = 1'b1;
                    w_nxt_err   = (Q_fb != r_d);
                    w_nxt_s     = 1'b0;
                    w_nxt_r     = 1'b0;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_W'(1);
                end
            end

            ST_DONE: begin
                w_nxt_state = ST_IDLE;
                w_nxt_ready = 1'b1;
                w_nxt_s     = 1'b0;
                w_nxt_r     = 1'b0;
            end

            default: begin
                w_nxt_state = ST_IDLE;
                w_nxt_ready = 1'b1;
                w_nxt_s     = 1'b0;
                w_nxt_r     = 1'b0;
            end
        endcase
    end

    assign S     = r_s;
    assign R     = r_r;
    assign En    = r_en;
    assign Ready = r_ready;
    assign Done  = r_done;
    assign Err   = r_err;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver: default, short (PULSE=1/HOLD=0) and skip-same
// instances, each observed cycle by cycle one time unit after the rising edge.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults, with a latch model and a stuck-at-0 override
    logic rst_a, wrreq_a, wrdata_a, s_a, r_a, en_a, ready_a, done_a, err_a;
    logic q_lat_a = 1'b0;
    logic stuck_a;
    logic q_fb_a;
    assign q_fb_a = stuck_a ? 1'b0 : q_lat_a;

    // Instance B: PULSE_CYC=1, HOLD_CYC=0
    logic rst_b, wrreq_b, wrdata_b, s_b, r_b, en_b, ready_b, done_b, err_b;
    logic q_lat_b = 1'b0;

    // Instance C: SKIP_SAME=1, feedback driven directly
    logic rst_c, wrreq_c, wrdata_c, q_fb_c, s_c, r_c, en_c, ready_c, done_c, err_c;

    sr_latch_driver dut_a (
        .Clk(clk), .Rst(rst_a), .WrReq(wrreq_a), .WrData(wrdata_a), .Q_fb(q_fb_a),
        .S(s_a), .R(r_a), .En(en_a), .Ready(ready_a), .Done(done_a), .Err(err_a)
    );

    sr_latch_driver #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(0), .SKIP_SAME(1'b0)) dut_b (
        .Clk(clk), .Rst(rst_b), .WrReq(wrreq_b), .WrData(wrdata_b), .Q_fb(q_lat_b),
        .S(s_b), .R(r_b), .En(en_b), .Ready(ready_b), .Done(done_b), .Err(err_b)
    );

    sr_latch_driver #(.SKIP_SAME(1'b1)) dut_c (
        .Clk(clk), .Rst(rst_c), .WrReq(wrreq_c), .WrData(wrdata_c), .Q_fb(q_fb_c),
        .S(s_c), .R(r_c), .En(en_c), .Ready(ready_c), .Done(done_c), .Err(err_c)
    );

    // Gated latch models: S/R are stable while En is high, so sampling mid-cycle suffices
    always @(negedge clk) begin
        if (en_a) begin
            if (s_a) q_lat_a <= 1'b1;
            else if (r_a) q_lat_a <= 1'b0;
        end
        if (en_b) begin
            if (s_b) q_lat_b <= 1'b1;
            else if (r_b) q_lat_b <= 1'b0;
        end
    end

    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_done   = 0;
    logic mon_on;
    logic [1:0] prev_sr;
    logic prev_en;

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Vectors are {S, R, En, Done, Ready, Err}
    function automatic logic [5:0] vec_a();
        return {s_a, r_a, en_a, done_a, ready_a, err_a};
    endfunction
    function automatic logic [5:0] vec_b();
        return {s_b, r_b, en_b, done_b, ready_b, err_b};
    endfunction
    function automatic logic [5:0] vec_c();
        return {s_c, r_c, en_c, done_c, ready_c, err_c};
    endfunction

    // One clock; in random mode also checks the S/R/En invariants on instance A
    task automatic tick();
        logic acc;
        acc = wrreq_a && ready_a && !rst_a;
        @(posedge clk);
        #1;
        if (acc) n_acc++;
        if (done_a) n_done++;
        if (mon_on) begin
            chk("A_SR_excl", {5'b0, s_a & r_a}, 6'b0);
            if ({s_a, r_a} != prev_sr) chk("A_SR_chg_En", {5'b0, prev_en | en_a}, 6'b0);
            if (done_a) chk("A_rand_err", {5'b0, err_a}, 6'b0);
        end
        prev_sr = {s_a, r_a};
        prev_en = en_a;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        wrreq_a = 1'b0; wrdata_a = 1'b0; stuck_a = 1'b0;
        wrreq_b = 1'b0; wrdata_b = 1'b0;
        wrreq_c = 1'b0; wrdata_c = 1'b0; q_fb_c = 1'b0;
        mon_on = 1'b0; prev_sr = 2'b00; prev_en = 1'b0;
        #1;
        chk("A_reset", vec_a(), 6'b000010);
        chk("B_reset", vec_b(), 6'b000010);
        chk("C_reset", vec_c(), 6'b000010);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();
        chk("A_idle", vec_a(), 6'b000010);

        // A: write 1 through the latch model
        wrreq_a = 1'b1; wrdata_a = 1'b1;
        tick(); wrreq_a = 1'b0;
        chk("A_w1_c0", vec_a(), 6'b100000);
        tick(); chk("A_w1_c1", vec_a(), 6'b100000);
        tick(); chk("A_w1_c2", vec_a(), 6'b101000);
        tick(); chk("A_w1_c3", vec_a(), 6'b101000);
        tick(); chk("A_w1_c4", vec_a(), 6'b100000);
        tick(); chk("A_w1_c5", vec_a(), 6'b000100);
        tick(); chk("A_w1_c6", vec_a(), 6'b000010);
        chk("A_w1_qfb", {5'b0, q_fb_a}, 6'b000001);

        // A: feedback stuck at 0, write 1 flags Err until the next accept
        stuck_a = 1'b1;
        wrreq_a = 1'b1; wrdata_a = 1'b1;
        tick(); wrreq_a = 1'b0;
        chk("A_st_c0", vec_a(), 6'b100000);
        repeat (4) tick();
        chk("A_st_c4", vec_a(), 6'b100000);
        tick(); chk("A_st_c5", vec_a(), 6'b000101);
        tick(); chk("A_st_c6", vec_a(), 6'b000011);
        repeat (2) tick();
        chk("A_st_idle", vec_a(), 6'b000011);
        wrreq_a = 1'b1; wrdata_a = 1'b0;
        tick(); wrreq_a = 1'b0;
        chk("A_st_clr", vec_a(), 6'b010000);
        repeat (5) tick();
        chk("A_st_w0_done", vec_a(), 6'b000100);
        tick();
        chk("A_st_w0_idle", vec_a(), 6'b000010);
        stuck_a = 1'b0;

        // A: reset in the middle of PULSE aborts without a clock edge
        wrreq_a = 1'b1; wrdata_a = 1'b1;
        tick(); wrreq_a = 1'b0;
        tick(); tick();
        chk("A_ab_pulse", vec_a(), 6'b101000);
        #2 rst_a = 1'b1;
        #1 chk("A_ab_async", vec_a(), 6'b000010);
        tick();
        chk("A_ab_in_rst", vec_a(), 6'b000010);
        rst_a = 1'b0;
        repeat (6) begin
            tick();
            chk("A_ab_nodone", vec_a(), 6'b000010);
        end

        // B: write 0 with WrReq held high; busy requests ignored, re-accept after Ready
        wrreq_b = 1'b1; wrdata_b = 1'b0;
        tick(); wrdata_b = 1'b1;
        chk("B_c0", vec_b(), 6'b010000);
        tick(); chk("B_c1", vec_b(), 6'b010000);
        tick(); chk("B_c2", vec_b(), 6'b011000);
        tick(); chk("B_c3", vec_b(), 6'b000100);
        tick(); chk("B_c4", vec_b(), 6'b000010);
        tick(); wrreq_b = 1'b0;
        chk("B_c5", vec_b(), 6'b100000);
        tick(); chk("B_c6", vec_b(), 6'b100000);
        tick(); chk("B_c7", vec_b(), 6'b101000);
        tick(); chk("B_c8", vec_b(), 6'b000100);
        tick(); chk("B_c9", vec_b(), 6'b000010);

        // C: matching data completes without an En pulse; a differing write runs fully
        q_fb_c = 1'b1;
        wrreq_c = 1'b1; wrdata_c = 1'b1;
        tick(); wrreq_c = 1'b0;
        chk("C_skip_c0", vec_c(), 6'b000100);
        tick(); chk("C_skip_c1", vec_c(), 6'b000010);
        wrreq_c = 1'b1; wrdata_c = 1'b0;
        tick(); wrreq_c = 1'b0; q_fb_c = 1'b0;
        chk("C_w0_c0", vec_c(), 6'b010000);
        tick(); chk("C_w0_c1", vec_c(), 6'b010000);
        tick(); chk("C_w0_c2", vec_c(), 6'b011000);
        tick(); chk("C_w0_c3", vec_c(), 6'b011000);
        tick(); chk("C_w0_c4", vec_c(), 6'b010000);
        tick(); chk("C_w0_c5", vec_c(), 6'b000100);
        tick(); chk("C_w0_c6", vec_c(), 6'b000010);

        // A: 200 random writes with random gaps and invariant monitoring
        n_acc = 0; n_done = 0; mon_on = 1'b1;
        for (int w = 0; w < 200; w++) begin
            logic got;
            repeat ($urandom_range(0, 3)) tick();
            wrreq_a = 1'b1;
            wrdata_a = 1'($urandom_range(0, 1));
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                got = ready_a;
                tick();
            end
            wrreq_a = 1'b0;
            chk("A_rand_accept", {5'b0, got}, 6'b000001);
        end
        repeat (12) tick();
        mon_on = 1'b0;
        chk_int("A_rand_accepts", n_acc, 200);
        chk_int("A_rand_done_per_acc", n_done, n_acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
